// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind a UART receiver,
// with occupancy status and sticky overflow / break flags.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid, in_data    received byte strobe and data from the receiver
//   in_break             break indication; a strobe during break stores nothing
//   out_ready            consumer takes the head byte this cycle
//   clr_flags            clears overflow / break_seen (a same-cycle set wins)
//   out_valid, out_data  head byte, zero while empty
//   count                occupancy 0..DEPTH
//   full, empty, almost_full  occupancy status
//   overflow, break_seen sticky error flags
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_break,
    input  logic                     out_ready,
    input  logic                     clr_flags,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     break_seen
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              break_seen_q, break_seen_d;
    logic              pop, push, drop;

    assign count       = count_q;
    assign out_valid   = count_q != '0;
    assign empty       = count_q == '0;
    assign full        = count_q == CW'(DEPTH);
    assign almost_full = count_q >= CW'(AF_LEVEL);
    assign out_data    = out_valid ? mem[rd_ptr_q] : '0;
    assign overflow    = overflow_q;
    assign break_seen  = break_seen_q;

    always_comb begin
        pop          = out_valid && out_ready;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push         = in_valid && !in_break && (!full || pop);
        drop         = in_valid && !in_break && full && !pop;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d      = (push && !pop) ? count_q + CW'(1) :
                       (pop && !push) ? count_q - CW'(1) : count_q;
        // Set events override a simultaneous clear.
        overflow_d   = drop || (overflow_q && !clr_flags);
        break_seen_d = (in_valid && in_break) || (break_seen_q && !clr_flags);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            break_seen_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            break_seen_q <= break_seen_d;
        end
    end

    // Storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr_q] <= in_data;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_break = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_flags = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       full, empty, almost_full, overflow, break_seen;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic [7:0] got[$];
    logic       m_ov = 1'b0;
    logic       m_bk = 1'b0;

    uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_break(in_break), .out_ready(out_ready), .clr_flags(clr_flags),
        .out_valid(out_valid), .out_data(out_data), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .overflow(overflow), .break_seen(break_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n = mq.size();
        check("count",       32'(count),       32'(n));
        check("out_valid",   32'(out_valid),   32'(n != 0));
        check("empty",       32'(empty),       32'(n == 0));
        check("full",        32'(full),        32'(n == DEPTH));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("out_data",    32'(out_data),    32'(n != 0 ? mq[0] : 8'h00));
        check("overflow",    32'(overflow),    32'(m_ov));
        check("break_seen",  32'(break_seen),  32'(m_bk));
    endtask

    // Drive one cycle: check outputs against the model, clock, then advance the model.
    task automatic step(input logic v, input logic [7:0] d, input logic b,
                        input logic r, input logic c, input logic rn);
        int  n;
        bit  pop, was_full;
        in_valid = v; in_data = d; in_break = b; out_ready = r; clr_flags = c; rst_n = rn;
        check_outputs();
        if (rn && out_valid && r) got.push_back(out_data);
        @(posedge clk);
        n = mq.size();
        pop = n != 0 && r;
        was_full = n == DEPTH;
        if (!rn) begin
            mq.delete();
            m_ov = 1'b0;
            m_bk = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (v && !b && (!was_full || pop)) mq.push_back(d);
            m_ov = (v && !b && was_full && !pop) ? 1'b1 : c ? 1'b0 : m_ov;
            m_bk = (v && b) ? 1'b1 : c ? 1'b0 : m_bk;
        end
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        step(1, d, 0, 0, 0, 1);
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 8'h00, 0, 1, 0, 1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(0, 8'h00, 0, 0, 0, 0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);

        // fill and drain
        got.delete();
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        check("fd_count3", 32'(count), 32'd3);
        drain(4);
        check("fd_n",  32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("fd_order", 32'(got[i]), 32'(8'h41 + i));
        check("fd_empty", 32'(empty), 32'd1);

        // overflow
        got.delete();
        for (int i = 0; i < 9; i++) begin
            push_byte(8'(i));
            if (i == 7) check("ov_full8", 32'(full), 32'd1);
        end
        check("ov_flag", 32'(overflow), 32'd1);
        drain(9);
        check("ov_n", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) check("ov_order", 32'(got[i]), 32'(i));
        step(0, 8'h00, 0, 0, 1, 1);
        check("ov_clr", 32'(overflow), 32'd0);

        // simultaneous push/pop when full
        got.delete();
        for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
        step(1, 8'hAA, 0, 1, 0, 1);
        check("pp_count", 32'(count), 32'd8);
        check("pp_ovf", 32'(overflow), 32'd0);
        drain(9);
        check("pp_n", 32'(got.size()), 32'd9);
        if (got.size() == 9) check("pp_last", 32'(got[8]), 32'h0AA);

        // break and flag priority
        push_byte(8'h55);
        step(1, 8'h00, 1, 0, 0, 1);
        check("bk_count", 32'(count), 32'd1);
        check("bk_set", 32'(break_seen), 32'd1);
        step(0, 8'h00, 1, 0, 0, 1);
        step(1, 8'h00, 1, 0, 1, 1);
        check("bk_prio", 32'(break_seen), 32'd1);
        step(0, 8'h00, 0, 0, 1, 1);
        check("bk_clr", 32'(break_seen), 32'd0);
        drain(2);

        // wrap-around with a steady two-deep queue, then a burst to six
        got.delete();
        push_byte(8'h80); push_byte(8'h81);
        for (int i = 0; i < 20; i++) step(1, 8'(8'h82 + i), 0, 1, 0, 1);
        drain(3);
        check("wr_n", 32'(got.size()), 32'd22);
        for (int i = 0; i < got.size(); i++) check("wr_order", 32'(got[i]), 32'(8'h80 + i));
        for (int i = 0; i < 6; i++) begin
            check("af_below", 32'(almost_full), 32'd0);
            push_byte(8'(i));
        end
        check("af_at6", 32'(almost_full), 32'd1);
        drain(7);

        // mid-operation reset
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
        step(1, 8'hEE, 0, 0, 0, 1);
        step(1, 8'h77, 0, 1, 1, 0);
        check("mr_count", 32'(count), 32'd0);
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_data", 32'(out_data), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom % 3) != 0, 8'($urandom), ($urandom % 10) == 0,
                 ($urandom % 5) < 2, ($urandom % 16) == 0, ($urandom % 300) != 0);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
